// File: rtl/m_secuenciador.sv
// m_secuenciador: instruction sequencer. Owns a writable program memory and
// replays it, one instruction at a time, into m_control, capturing each result.
// Supports run and single-step modes, a programmable inclusive end address,
// an all-ones halt opcode, abort, and a configurable control-unit latency.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   esc_en/dir/dato   program-memory write port (honoured only while idle)
//   inicio            start pulse; dir_fin (last address, inclusive) latched here
//   modo_paso, paso   single-step mode select and step pulse
//   detener           abort the current run
//   resultado_in      result from m_control
//   instruccion       instruction to m_control; instr_valida while executing
//   resultado         last captured result; resultado_valido one-cycle pulse
//   pc, cuenta        current address, instructions executed this run
//   ocupado           sequencer not idle
//   fin               one-cycle pulse at normal end of run
//   alto              sticky: run ended on the halt opcode
module m_secuenciador #(
    parameter int unsigned ANCHO_INSTR   = 20,
    parameter int unsigned ANCHO_RES     = 32,
    parameter int unsigned ANCHO_DIR     = 5,
    parameter int unsigned LATENCIA_CTRL = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   esc_en,
    input  logic [ANCHO_DIR-1:0]   esc_dir,
    input  logic [ANCHO_INSTR-1:0] esc_dato,
    input  logic                   inicio,
    input  logic [ANCHO_DIR-1:0]   dir_fin,
    input  logic                   modo_paso,
    input  logic                   paso,
    input  logic                   detener,
    input  logic [ANCHO_RES-1:0]   resultado_in,
    output logic [ANCHO_INSTR-1:0] instruccion,
    output logic                   instr_valida,
    output logic [ANCHO_RES-1:0]   resultado,
    output logic                   resultado_valido,
    output logic [ANCHO_DIR-1:0]   pc,
    output logic [ANCHO_DIR:0]     cuenta,
    output logic                   ocupado,
    output logic                   fin,
    output logic                   alto
);

    localparam int unsigned PROFUNDIDAD = 2 ** ANCHO_DIR;
    localparam int unsigned ANCHO_ESP   = (LATENCIA_CTRL < 2) ? 1 : $clog2(LATENCIA_CTRL + 1);
    localparam logic [ANCHO_INSTR-1:0] OP_ALTO = {ANCHO_INSTR{1'b1}};

    typedef enum logic [1:0] {REPOSO, LEER, ESPERA, PAUSA} estado_t;

    estado_t                estado, estado_sig;
    logic [ANCHO_INSTR-1:0] mem [PROFUNDIDAD];
    logic [ANCHO_INSTR-1:0] dato_mem;
    logic [ANCHO_ESP-1:0]   espera, espera_sig;
    logic [ANCHO_DIR-1:0]   dir_fin_q, dir_fin_sig;

    logic [ANCHO_INSTR-1:0] instruccion_sig;
    logic                   instr_valida_sig;
    logic [ANCHO_RES-1:0]   resultado_sig;
    logic                   resultado_valido_sig;
    logic [ANCHO_DIR-1:0]   pc_sig;
    logic [ANCHO_DIR:0]     cuenta_sig;
    logic                   fin_sig;
    logic                   alto_sig;

    assign dato_mem = mem[pc];
    assign ocupado  = (estado != REPOSO);

    // Program memory: loadable only while idle, never reset.
    always_ff @(posedge clk) begin
        if (esc_en && (estado == REPOSO)) begin
            mem[esc_dir] <= esc_dato;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado           <= REPOSO;
            espera           <= '0;
            dir_fin_q        <= '0;
            instruccion      <= '0;
            instr_valida     <= 1'b0;
            resultado        <= '0;
            resultado_valido <= 1'b0;
            pc               <= '0;
            cuenta           <= '0;
            fin              <= 1'b0;
            alto             <= 1'b0;
        end else begin
            estado           <= estado_sig;
            espera           <= espera_sig;
            dir_fin_q        <= dir_fin_sig;
            instruccion      <= instruccion_sig;
            instr_valida     <= instr_valida_sig;
            resultado        <= resultado_sig;
            resultado_valido <= resultado_valido_sig;
            pc               <= pc_sig;
            cuenta           <= cuenta_sig;
            fin              <= fin_sig;
            alto             <= alto_sig;
        end
    end

    // Next-state and next-output decode; abort overrides everything when busy.
    always_comb begin
        estado_sig           = estado;
        espera_sig           = espera;
        dir_fin_sig          = dir_fin_q;
        instruccion_sig      = instruccion;
        instr_valida_sig     = instr_valida;
        resultado_sig        = resultado;
        resultado_valido_sig = 1'b0;
        pc_sig               = pc;
        cuenta_sig           = cuenta;
        fin_sig              = 1'b0;
        alto_sig             = alto;

        if ((estado != REPOSO) && detener) begin
            estado_sig       = REPOSO;
            instr_valida_sig = 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        estado_sig  = LEER;
                        pc_sig      = '0;
                        dir_fin_sig = dir_fin;
                        cuenta_sig  = '0;
                        alto_sig    = 1'b0;
                    end
                end
                LEER: begin
                    if (dato_mem == OP_ALTO) begin
                        estado_sig = REPOSO;
                        alto_sig   = 1'b1;
                        fin_sig    = 1'b1;
                    end else begin
                        instruccion_sig  = dato_mem;
                        instr_valida_sig = 1'b1;
                        espera_sig       = ANCHO_ESP'(LATENCIA_CTRL);
                        estado_sig       = ESPERA;
                    end
                end
                ESPERA: begin
                    if (espera == ANCHO_ESP'(1)) begin
                        resultado_sig        = resultado_in;
                        resultado_valido_sig = 1'b1;
                        cuenta_sig           = cuenta + (ANCHO_DIR + 1)'(1);
                        instr_valida_sig     = 1'b0;
                        if (pc == dir_fin_q) begin
                            estado_sig = REPOSO;
                            fin_sig    = 1'b1;
                        end else begin
                            pc_sig     = pc + ANCHO_DIR'(1);
                            estado_sig = modo_paso ? PAUSA : LEER;
                        end
                    end else begin
                        espera_sig = espera - ANCHO_ESP'(1);
                    end
                end
                PAUSA: begin
                    if (paso || !modo_paso) begin
                        estado_sig = LEER;
                    end
                end
                default: estado_sig = REPOSO;
            endcase
        end
    end

endmodule
